padovan_seq: RTL and testbench
==============================

# padovan_seq

Microsequencer that drives the combinational ALU: it issues opcodes and operands, captures the results and flags, and uses them to emit successive Padovan terms P(0)=P(1)=P(2)=1, P(n)=P(n-2)+P(n-3). Terms leave over a valid/ready stream. The block sits between the start/count control inputs and the result consumer (display or serial path). It is the ALU's initiator: the ALU computes, and this block decides what it computes next.

## Interface
- DATAWIDTH, 8, width of ALU buses, terms and term count
- SELECTION, 3, ALU opcode width
- CLOCK_50  in  1  system clock, rising edge
- RESET_InLow  in  1  synchronous, active-low reset
- sStart  in  1  start request, sampled in IDLE only
- sNumTerms  in  DATAWIDTH  number of terms requested, sampled with sStart
- sReady  in  1  downstream accepts sTerm
- sAluResult  in  DATAWIDTH  ALU result bus C
- sAluZero  in  1  ALU zero flag
- sAluCarry, sAluNegative, sAluOverflow  in  1 each  accepted, unused
- sAluSel  out  SELECTION  ALU opcode
- sAluBusA, sAluBusB  out  DATAWIDTH  ALU operands
- sTerm  out  DATAWIDTH  current term
- sTermValid  out  1  sTerm valid
- sBusy  out  1  state is not IDLE
- sDone  out  1  one-cycle pulse at sequence end
- sWrap  out  1  sticky: sequence truncated by unsigned wrap

## Operation
- ALU opcodes used: 000 PASS, 010 ADD (A+B), 110 DEC (A-1). sAluSel, sAluBusA and sAluBusB are combinational from state and registers. The result is captured at the end of the same cycle.
- Window registers rA, rB, rC hold P(k), P(k+1), P(k+2). Each has a poison bit pA, pB, pC. Count register rCount.
- IDLE: ALU driven PASS with both buses at 0.
  - On sStart with sNumTerms≠0: rA=rB=rC=1, poisons cleared, rCount=sNumTerms, sWrap cleared, go to EMIT.
  - On sStart with sNumTerms=0: sWrap cleared, go to DONE.
- EMIT: sTerm=rA.
  - If pA=1: sTermValid=0, sWrap set, go to DONE.
  - Otherwise sTermValid=1. Hold until sReady=1; on that handshake go to DEC.
- DEC: sAluSel=DEC, A=rCount, rCount←sAluResult. If sAluZero=1, go to DONE; otherwise go to ADD.
- ADD: sAluSel=ADD, A=rA, B=rB, sum=sAluResult.
  - Shift the window: rA←rB, rB←rC, rC←sum; pA←pB, pB←pC.
  - pC←(sum<rA) | pA | pB. Wrap is detected internally. The ALU carry flag is not used.
  - Go to EMIT.
- DONE: sDone=1 for one cycle, then go to IDLE. sWrap holds until the next accepted start.
- sStart while busy is ignored. sTermValid, once raised, stays high with sTerm stable until the handshake.
- Arithmetic is unsigned, modulo 2^DATAWIDTH. No term whose computation wrapped is ever emitted.

## Timing
- Reset, and reset mid-sequence: state=IDLE. All registers and outputs are 0: sTermValid, sBusy, sDone, sWrap, sTerm, sAluSel=000, both buses 0. An in-flight term is dropped with no handshake.
- Start sampled at cycle 0. First sTermValid in cycle 1.
- With sReady held high, term i is valid in cycle 1+3i, so throughput is 3 cycles per term. sDone pulses in cycle 3N.
- Each cycle of sReady=0 in EMIT adds one cycle.
- Wrap stop: sDone pulses in the cycle after the EMIT that found pA=1.

## Structure
- Shared include file padovan_defs.vh holds:
  - state encodings IDLE, EMIT, DEC, ADD, DONE;
  - ALU opcode constants PASS, ADD, DEC.
- One sub-module is natural: padovan_window. It is the 3-entry shift window with poison bits, load-ones and shift-in-sum ports, and it does the sum<rA compare.
- The FSM and count logic stay in padovan_seq.

## Test plan
- DATAWIDTH=8, sNumTerms=6, sReady=1 -> terms 1,1,1,2,2,3 in cycles 1,4,7,10,13,16. sDone in cycle 18. sWrap=0.
- sNumTerms=30 -> 21 terms emitted, ending ...,151,200. sDone pulses, sWrap=1 (P(21)=265 wraps).
- sNumTerms=0 -> no sTermValid. sDone in cycle 1. sWrap=0.
- sNumTerms=4, sReady low for 5 cycles on term 2 -> sTerm=1 stays stable and valid for the whole stall. Sequence completes 5 cycles late with the correct terms.
- RESET_InLow low during term 3, then sStart with sNumTerms=3 -> all outputs 0 after reset edge. Fresh sequence 1,1,1. sStart pulsed mid-sequence has no effect.

Source files
------------

// File: rtl/padovan_pkg.sv
// Shared definitions for the Padovan microsequencer.
//   padStateT : sequencer FSM states
//   OP_*      : ALU opcodes issued by the sequencer
package padovan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_DEC,
    S_ADD,
    S_DONE
  } padStateT;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b110;

endpackage

// File: rtl/padovan_window.sv
// Three-entry Padovan window P(k), P(k+1), P(k+2) with per-entry poison bits.
// Ports:
//   clk, rstN  : clock, synchronous active-low reset
//   loadOnes   : load 1,1,1 and clear all poison bits
//   shiftIn    : shift window down by one and append sum
//   sum        : new term (rA + rB computed by the external ALU)
//   winA, winB : oldest two entries, feed the ALU operands
//   poisonA    : oldest entry came from a wrapped computation
module padovan_window #(
  parameter int unsigned DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 loadOnes,
  input  logic                 shiftIn,
  input  logic [DATAWIDTH-1:0] sum,
  output logic [DATAWIDTH-1:0] winA,
  output logic [DATAWIDTH-1:0] winB,
  output logic                 poisonA
);

  logic [DATAWIDTH-1:0] rA, rB, rC;
  logic                 pA, pB, pC;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      rA <= '0;
      rB <= '0;
      rC <= '0;
      pA <= 1'b0;
      pB <= 1'b0;
      pC <= 1'b0;
    end else if (loadOnes) begin
      rA <= DATAWIDTH'(1);
      rB <= DATAWIDTH'(1);
      rC <= DATAWIDTH'(1);
      pA <= 1'b0;
      pB <= 1'b0;
      pC <= 1'b0;
    end else if (shiftIn) begin
      rA <= rB;
      rB <= rC;
      rC <= sum;
      pA <= pB;
      pB <= pC;
      // An unsigned sum smaller than an addend means it wrapped; poison also
      // propagates from any poisoned operand.
      pC <= (sum < rA) | pA | pB;
    end
  end

  assign winA    = rA;
  assign winB    = rB;
  assign poisonA = pA;

endmodule

// File: rtl/padovan_seq.sv
// Padovan microsequencer: drives an external combinational ALU to generate
// P(0)=P(1)=P(2)=1, P(n)=P(n-2)+P(n-3), emitted over a valid/ready stream.
// Ports:
//   CLOCK_50, RESET_InLow     : clock, synchronous active-low reset
//   sStart, sNumTerms         : start request and term count (IDLE only)
//   sReady                    : downstream accepts sTerm
//   sAluResult, sAluZero      : ALU result bus and zero flag
//   sAluCarry/Negative/Overflow : ALU flags, not used
//   sAluSel, sAluBusA/B       : ALU opcode and operands
//   sTerm, sTermValid         : output term stream
//   sBusy, sDone, sWrap       : status (not idle, end pulse, sticky wrap stop)
module padovan_seq
  import padovan_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned SELECTION = 3
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_InLow,
  input  logic                 sStart,
  input  logic [DATAWIDTH-1:0] sNumTerms,
  input  logic                 sReady,
  input  logic [DATAWIDTH-1:0] sAluResult,
  input  logic                 sAluZero,
  input  logic                 sAluCarry,
  input  logic                 sAluNegative,
  input  logic                 sAluOverflow,
  output logic [SELECTION-1:0] sAluSel,
  output logic [DATAWIDTH-1:0] sAluBusA,
  output logic [DATAWIDTH-1:0] sAluBusB,
  output logic [DATAWIDTH-1:0] sTerm,
  output logic                 sTermValid,
  output logic                 sBusy,
  output logic                 sDone,
  output logic                 sWrap
);

  padStateT             state, stateNext;
  logic [DATAWIDTH-1:0] rCount;
  logic                 rWrap;
  logic                 loadOnes, shiftIn;
  logic [DATAWIDTH-1:0] winA, winB;
  logic                 poisonA;
  logic                 unusedAluFlags;

  assign unusedAluFlags = sAluCarry ^ sAluNegative ^ sAluOverflow;

  padovan_window #(.DATAWIDTH(DATAWIDTH)) uWindow (
    .clk     (CLOCK_50),
    .rstN    (RESET_InLow),
    .loadOnes(loadOnes),
    .shiftIn (shiftIn),
    .sum     (sAluResult),
    .winA    (winA),
    .winB    (winB),
    .poisonA (poisonA)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_InLow) begin
      state  <= S_IDLE;
      rCount <= '0;
      rWrap  <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        S_IDLE: if (sStart) begin
          rCount <= sNumTerms;
          rWrap  <= 1'b0;
        end
        S_EMIT: if (poisonA) rWrap <= 1'b1;
        S_DEC:  rCount <= sAluResult;
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext  = state;
    sAluSel    = SELECTION'(OP_PASS);
    sAluBusA   = '0;
    sAluBusB   = '0;
    sTermValid = 1'b0;
    loadOnes   = 1'b0;
    shiftIn    = 1'b0;
    case (state)
      S_IDLE: begin
        if (sStart) begin
          if (sNumTerms != '0) begin
            loadOnes  = 1'b1;
            stateNext = S_EMIT;
          end else begin
            stateNext = S_DONE;
          end
        end
      end
      S_EMIT: begin
        if (poisonA) begin
          stateNext = S_DONE;
        end else begin
          sTermValid = 1'b1;
          if (sReady) stateNext = S_DEC;
        end
      end
      S_DEC: begin
        sAluSel   = SELECTION'(OP_DEC);
        sAluBusA  = rCount;
        stateNext = sAluZero ? S_DONE : S_ADD;
      end
      S_ADD: begin
        sAluSel   = SELECTION'(OP_ADD);
        sAluBusA  = winA;
        sAluBusB  = winB;
        shiftIn   = 1'b1;
        stateNext = S_EMIT;
      end
      S_DONE: stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  assign sTerm = winA;
  assign sBusy = (state != S_IDLE);
  assign sDone = (state == S_DONE);
  assign sWrap = rWrap;

endmodule

// File: tb/tb_padovan_seq.sv
// Scoreboard bench for padovan_seq with a behavioural ALU model.
module tb_padovan_seq;
  localparam int DW  = 8;
  localparam int SEL = 3;

  logic          clk = 1'b0;
  logic          rstN, sStart, sReady;
  logic [DW-1:0] sNumTerms;
  logic [DW-1:0] aluRes, busA, busB, sTerm;
  logic          aluZero, aluCarry, aluNeg, aluOvf;
  logic [SEL-1:0] aluSel;
  logic          sTermValid, sBusy, sDone, sWrap;

  always #5 clk = ~clk;

  padovan_seq #(.DATAWIDTH(DW), .SELECTION(SEL)) dut (
    .CLOCK_50    (clk),
    .RESET_InLow (rstN),
    .sStart      (sStart),
    .sNumTerms   (sNumTerms),
    .sReady      (sReady),
    .sAluResult  (aluRes),
    .sAluZero    (aluZero),
    .sAluCarry   (aluCarry),
    .sAluNegative(aluNeg),
    .sAluOverflow(aluOvf),
    .sAluSel     (aluSel),
    .sAluBusA    (busA),
    .sAluBusB    (busB),
    .sTerm       (sTerm),
    .sTermValid  (sTermValid),
    .sBusy       (sBusy),
    .sDone       (sDone),
    .sWrap       (sWrap)
  );

  // Combinational ALU: PASS / ADD / DEC.
  always_comb begin
    aluRes   = busA;
    aluCarry = 1'b0;
    case (aluSel)
      3'b010:  {aluCarry, aluRes} = {1'b0, busA} + {1'b0, busB};
      3'b110:  {aluCarry, aluRes} = {1'b0, busA} - 9'd1;
      default: aluRes = busA;
    endcase
    aluZero = (aluRes == '0);
    aluNeg  = aluRes[DW-1];
    aluOvf  = 1'b0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int startCyc = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {int term; int cycle;} expT;
  expT q[$];

  int pad[21] = '{1, 1, 1, 2, 2, 3, 4, 5, 7, 9, 12, 16, 21, 28, 37, 49, 65, 86, 114, 151, 200};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: pops and compares on every handshake, checks stall stability.
  expT           mE;
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevTerm  = '0;
  always @(negedge clk) begin
    if (!rstN) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        chk("stall_valid", int'(sTermValid), 1);
        chk("stall_term", int'(sTerm), int'(prevTerm));
      end
      if (sTermValid && sReady) begin
        if (q.size() == 0) begin
          chk("unexpected_term", int'(sTerm), -1);
        end else begin
          mE = q.pop_front();
          chk("term", int'(sTerm), mE.term);
          if (mE.cycle >= 0) chk("term_cycle", cyc - startCyc, mE.cycle);
        end
      end
      prevStall = sTermValid && !sReady;
      prevTerm  = sTerm;
    end
  end

  task automatic pushTerms(input int n, input bit withCycles);
    for (int i = 0; i < n; i++) q.push_back('{pad[i], withCycles ? 1 + 3 * i : -1});
  endtask

  task automatic startSeq(input int n);
    @(posedge clk); #2;
    sStart    = 1'b1;
    sNumTerms = DW'(n);
    startCyc  = cyc;
    @(posedge clk); #2;
    sStart = 1'b0;
  endtask

  task automatic waitRel(input int r);
    while (cyc - startCyc < r) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic waitDone(input string name, input int expCyc, input int expWrap);
    bit seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (sDone) seen = 1'b1;
    end
    if (!seen) begin
      chk({name, "_done_timeout"}, 0, 1);
    end else begin
      chk({name, "_done_cycle"}, cyc - startCyc, expCyc);
      chk({name, "_wrap"}, int'(sWrap), expWrap);
    end
    chk({name, "_queue_left"}, q.size(), 0);
    q.delete();
    @(negedge clk);
    chk({name, "_done_pulse_end"}, int'(sDone), 0);
    chk({name, "_idle"}, int'(sBusy), 0);
  endtask

  task automatic checkZero(input string name);
    chk({name, "_valid"}, int'(sTermValid), 0);
    chk({name, "_busy"}, int'(sBusy), 0);
    chk({name, "_done"}, int'(sDone), 0);
    chk({name, "_wrap"}, int'(sWrap), 0);
    chk({name, "_term"}, int'(sTerm), 0);
    chk({name, "_sel"}, int'(aluSel), 0);
    chk({name, "_busA"}, int'(busA), 0);
    chk({name, "_busB"}, int'(busB), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rstN      = 1'b0;
    sStart    = 1'b0;
    sReady    = 1'b1;
    sNumTerms = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkZero("reset");
    @(posedge clk); #2;
    rstN = 1'b1;

    // Six terms, ready always high, exact timing.
    pushTerms(6, 1'b1);
    startSeq(6);
    waitDone("n6", 18, 0);

    // Wrap stop after P(20)=200.
    pushTerms(21, 1'b0);
    startSeq(30);
    waitDone("n30", 65, 1);

    // Zero terms: immediate done, wrap cleared.
    startSeq(0);
    waitDone("n0", 1, 0);

    // Five-cycle stall on term index 2.
    pushTerms(4, 1'b0);
    startSeq(4);
    waitRel(7);
    sReady = 1'b0;
    waitRel(12);
    sReady = 1'b1;
    waitDone("stall", 17, 0);

    // Reset while term 3 is pending.
    pushTerms(3, 1'b0);
    startSeq(30);
    waitRel(8);
    sReady = 1'b0;
    waitRel(10);
    rstN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkZero("midreset");
    chk("midreset_queue_left", q.size(), 0);
    q.delete();
    @(posedge clk); #2;
    rstN   = 1'b1;
    sReady = 1'b1;

    // Fresh sequence; a start pulse mid-sequence is ignored.
    pushTerms(3, 1'b0);
    startSeq(3);
    waitRel(2);
    sStart    = 1'b1;
    sNumTerms = DW'(9);
    @(posedge clk); #2;
    sStart = 1'b0;
    waitDone("restart", 9, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
